// File: rtl/s38417_bank_scan_ctrl_if.sv
// Handshake/result bundle between the test/control FSM, the bank-scan
// sequencer and the bank-compare datapath.
interface s38417_bank_scan_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] ref_in;
  logic [WIDTH-1:0] data_in;
  logic [2:0]       sel;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [2:0]       match_vec;
  logic             all_match;
  logic [WIDTH-1:0] sig;
  logic             valid;

  modport master (
    output start, abort, ref_in, data_in,
    input  sel, busy, done, aborted, match_vec, all_match, sig, valid
  );

  modport slave (
    input  start, abort, ref_in, data_in,
    output sel, busy, done, aborted, match_vec, all_match, sig, valid
  );
endinterface

// File: rtl/s38417_bank_scan_ctrl.sv
// Three-phase one-hot bank-select sequencer: drives g826/g823/g853 in turn,
// waits SETTLE cycles for the compare cone, then samples match and signature.
module s38417_bank_scan_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1
) (
  input logic                    CK,
  input logic                    RST,
  s38417_bank_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q,     state_d;
  logic [PHASE_W-1:0] phase_q,     phase_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [2:0]         sel_q,       sel_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               aborted_q,   aborted_d;
  logic [2:0]         match_vec_q, match_vec_d;
  logic               all_match_q, all_match_d;
  logic [WIDTH-1:0]   sig_q,       sig_d;
  logic               valid_q,     valid_d;
  logic               hit;

  assign hit = (bus.data_in == bus.ref_in);

  // Next-state and next-output decode; sel/busy are derived from the next
  // state so they come straight out of flops with no input-to-output path.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    match_vec_d = match_vec_q;
    all_match_d = all_match_q;
    sig_d       = sig_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d     = DRIVE;
          phase_d     = '0;
          cnt_d       = CNT_W'(SETTLE);
          match_vec_d = '0;
          all_match_d = 1'b0;
          sig_d       = '0;
          valid_d     = 1'b0;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d     = IDLE;
          phase_d     = '0;
          aborted_d   = 1'b1;
          match_vec_d = '0;
          all_match_d = 1'b0;
          sig_d       = '0;
          valid_d     = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      SAMPLE: begin
        // An abort here discards the capture of the current phase.
        if (bus.abort) begin
          state_d     = IDLE;
          phase_d     = '0;
          aborted_d   = 1'b1;
          match_vec_d = '0;
          all_match_d = 1'b0;
          sig_d       = '0;
          valid_d     = 1'b0;
        end else begin
          match_vec_d = match_vec_q | (3'(hit) << phase_q);
          sig_d       = sig_q ^ bus.data_in;
          if (phase_q == PHASE_W'(2)) begin
            state_d     = DONE;
            phase_d     = '0;
            done_d      = 1'b1;
            valid_d     = 1'b1;
            all_match_d = &match_vec_d;
          end else begin
            state_d = DRIVE;
            phase_d = PHASE_W'(phase_q + PHASE_W'(1));
            cnt_d   = CNT_W'(SETTLE);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    sel_d  = busy_d ? (3'b001 << phase_d) : 3'b000;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      match_vec_q <= '0;
      all_match_q <= 1'b0;
      sig_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      match_vec_q <= match_vec_d;
      all_match_q <= all_match_d;
      sig_q       <= sig_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.match_vec = match_vec_q;
  assign bus.all_match = all_match_q;
  assign bus.sig       = sig_q;
  assign bus.valid     = valid_q;

endmodule

// File: doc/s38417_bank_scan_ctrl.md
Name: s38417_bank_scan_ctrl

Overview:
Sequencer for the three-way one-hot bank-select datapath. The datapath uses select lines g826, g823 and g853 to pick one register bank and compare it against the g785..g813 reference code. This block drives those select lines one phase at a time, waits for the combinational compare cone to settle, then samples the selected word against a reference. It returns per-phase match flags and an XOR signature of the three sampled words, and sits between the test/control FSM and the bank-compare logic.

Parameters:
WIDTH, 8, width of the selected bank word and the reference code.
SETTLE, 1, extra cycles each select phase is held before sampling (0..15).

Ports:
CK  input  1  clock; all state updates on rising edge.
RST  input  1  asynchronous, active-high reset.
start  input  1  request a scan; accepted only in IDLE.
abort  input  1  cancel an in-progress scan.
ref_in  input  WIDTH  reference code; sampled in each SAMPLE cycle.
data_in  input  WIDTH  word returned by the bank mux for the current select.
sel  output  3  one-hot bank select: bit0 drives g826, bit1 drives g823, bit2 drives g853.
busy  output  1  high in DRIVE and SAMPLE.
done  output  1  one-cycle pulse when a scan completes.
aborted  output  1  one-cycle pulse when a scan is cancelled.
match_vec  output  3  bit p = (data_in == ref_in) sampled in phase p.
all_match  output  1  AND of match_vec; valid only when valid=1.
sig  output  WIDTH  XOR of the three sampled data_in words.
valid  output  1  high from the DONE cycle until the next accepted start, abort or reset.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, phase=0, sel=000, busy=0, done=0, aborted=0, match_vec=000, all_match=0, sig=0, valid=0.
- All outputs are registered. sel is a decode of state/phase registers with no glitching path from inputs.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - sel=000.
  - start=1 and abort=0 → DRIVE next cycle with phase=0, settle counter=SETTLE, match_vec=000, sig=0, valid=0.
- DRIVE:
  - sel=one-hot(phase), busy=1.
  - Counter decrements each cycle; at counter=0 → SAMPLE. DRIVE therefore lasts SETTLE+1 cycles.
- SAMPLE:
  - One cycle; sel is held at one-hot(phase).
  - match_vec[phase] <= (data_in==ref_in); sig <= sig ^ data_in.
  - phase<2 → phase+1, counter reload, DRIVE. phase=2 → DONE.
- DONE:
  - One cycle; sel=000, busy=0, done=1, valid=1, all_match <= &match_vec (including the last phase's update).
  - Returns to IDLE next cycle. Results hold until the next accepted start.
- Latency: done asserts exactly 3*(SETTLE+2)+1 cycles after the edge that accepts start. SETTLE=1 gives 10 cycles.
- start while busy or in DONE: ignored, no queueing.
- abort in DRIVE or SAMPLE:
  - Next cycle state=IDLE, sel=000, aborted=1 for one cycle.
  - match_vec, sig, all_match and valid are cleared to 0.
  - A SAMPLE-cycle capture coincident with abort is discarded.
- abort in IDLE or DONE: no effect, no aborted pulse.
- start and abort both high in IDLE: abort wins, start is not accepted, no pulse.
- sel is never multi-hot, in any cycle.
- sel is 000 in IDLE, DONE and the cycle after reset deassertion.
- phase never exceeds 2.
- RST asserted mid-scan: all registers go to reset values immediately (asynchronous) and sel drops to 000 without waiting for a clock.
- SETTLE=0: DRIVE lasts 1 cycle and each phase is 2 cycles.

Test Plan:
- Reset, then start with SETTLE=1, ref_in=8'hA5, data_in=8'hA5 for all phases:
  - sel sequence 001,001,001,010,010,010,100,100,100,000.
  - done in cycle 10, match_vec=111, all_match=1, sig=8'hA5, valid=1.
- ref_in=8'h3C; data_in=8'h3C in phase 0, 8'h00 in phase 1, 8'hFF in phase 2 → match_vec=001, all_match=0, sig=8'hC3.
- abort in the SAMPLE cycle of phase 1 → aborted pulse one cycle later, sel=000, match_vec=000, sig=0, valid=0, no done.
- start pulsed every cycle during a scan → exactly one done; the second scan begins only on start after returning to IDLE.
- SETTLE=0 run → done 7 cycles after accept; start+abort together in IDLE → stays IDLE, no pulses.
- Assert RST asynchronously between clock edges mid-DRIVE → sel=000 and busy=0 before the next CK edge; every cycle of a randomized run checks sel is one-hot or zero.
